spw_buffer_ctrl: RTL and testbench

SPW_BUFFER_CTRL -- requirements
Module: spw_buffer_ctrl

---
 rtl/spw_buffer_ctrl.sv | 152 +++++++++++++++
 tb/tb_spw_buffer_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spw_buffer_ctrl.sv
// spw_buffer_ctrl: controller that runs an external buffer as a single
// in-order FIFO shared by two requesters.
//
// Each slot carries a one-bit source tag so the consumer can see which
// requester wrote the head entry.
//
// Build option SPW_BUF_CTRL_RR_EN:
//   - When defined, contention is resolved round-robin using a last_grant
//     register.
//   - When undefined, req0 always wins contention and no last_grant
//     register exists.
//
// Payload storage lives in the attached buffer and is never reset; only the
// pointers, count and tags are.
module spw_buffer_ctrl #(
    parameter int PTR_WIDTH  = 3,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req0_valid_i,
    input  logic [DATA_WIDTH-1:0] req0_data_i,
    output logic                  req0_ready_o,
    input  logic                  req1_valid_i,
    input  logic [DATA_WIDTH-1:0] req1_data_i,
    output logic                  req1_ready_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_src_o,
    output logic [PTR_WIDTH:0]    count_o,
    output logic                  buf_wr_en_o,
    output logic [PTR_WIDTH-1:0]  buf_wr_ptr_o,
    output logic [DATA_WIDTH-1:0] buf_wr_data_o,
    output logic                  buf_rd_en_o,
    output logic [PTR_WIDTH-1:0]  buf_rd_ptr_o,
    input  logic [DATA_WIDTH-1:0] buf_rd_data_i
);

    localparam int                DEPTH   = 2 ** PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH + 1)'(DEPTH);

    logic [PTR_WIDTH-1:0] wr_ptr_r;
    logic [PTR_WIDTH-1:0] rd_ptr_r;
    logic [PTR_WIDTH:0]   count_r;
    logic [DEPTH-1:0]     src_tag_r;

    logic full_s;
    logic empty_s;
    logic winner_s;
    logic accept_s;
    logic push_s;
    logic pop_s;

`ifdef SPW_BUF_CTRL_RR_EN
    logic last_grant_r;
`endif

    assign full_s  = (count_r == DEPTH_C);
    assign empty_s = (count_r == {(PTR_WIDTH + 1){1'b0}});

    // Pick the requester that may push this cycle.
    always_comb begin
        winner_s = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
`ifdef SPW_BUF_CTRL_RR_EN
            // On contention, the requester that did not win last time wins.
            winner_s = ~last_grant_r;
`else
            // On contention, req0 always wins.
            winner_s = 1'b0;
`endif
        end else if (req1_valid_i) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Acceptance is gated by reset and by full only.
    // A pop in the same cycle does not free a slot for a push.
    assign accept_s     = rst_ni && !full_s;
    assign req0_ready_o = accept_s && req0_valid_i && (winner_s == 1'b0);
    assign req1_ready_o = accept_s && req1_valid_i && (winner_s == 1'b1);
    assign push_s       = req0_ready_o || req1_ready_o;

    // Pop only when a head entry exists.
    // Consumer ready while empty is ignored.
    assign out_valid_o = !empty_s;
    assign pop_s       = rst_ni && out_valid_o && out_ready_i;

    assign buf_wr_en_o   = push_s;
    assign buf_wr_ptr_o  = wr_ptr_r;
    assign buf_wr_data_o = winner_s ? req1_data_i : req0_data_i;

    assign buf_rd_en_o  = pop_s;
    assign buf_rd_ptr_o = rd_ptr_r;
    assign out_data_o   = buf_rd_data_i;
    assign out_src_o    = src_tag_r[rd_ptr_r];
    assign count_o      = count_r;

    // Advance the pointers and occupancy count.
    // The pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {PTR_WIDTH{1'b0}};
            rd_ptr_r <= {PTR_WIDTH{1'b0}};
            count_r  <= {(PTR_WIDTH + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_WIDTH'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_WIDTH'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_WIDTH + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_WIDTH + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Record which requester wrote each slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_tag_r <= {DEPTH{1'b0}};
        end else if (push_s) begin
            src_tag_r[wr_ptr_r] <= winner_s;
        end else begin
            src_tag_r <= src_tag_r;
        end
    end

`ifdef SPW_BUF_CTRL_RR_EN
    // Remember the last requester whose push was actually accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_r <= 1'b1;
        end else if (push_s) begin
            last_grant_r <= winner_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

endmodule

// File: tb/tb_spw_buffer_ctrl.sv
// Testbench for spw_buffer_ctrl.
// It provides a behavioural buffer memory and a queue-based reference FIFO.
module tb_spw_buffer_ctrl;

    localparam int PW    = 3;
    localparam int DW    = 128;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          v0, v1, ordy;
    logic [DW-1:0] d0, d1;
    logic          req0_ready, req1_ready, out_valid, out_src;
    logic [DW-1:0] out_data, buf_wr_data, buf_rd_data;
    logic [PW:0]   count;
    logic          buf_wr_en, buf_rd_en;
    logic [PW-1:0] buf_wr_ptr, buf_rd_ptr;

    logic [DW-1:0] mem [DEPTH];
    logic [DW:0]   q [$];
    bit            m_lg;
    int            wp, rp;
    int            n_pass = 0;
    int            n_total = 0;

    always #5 clk = ~clk;

    spw_buffer_ctrl #(.PTR_WIDTH(PW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req0_valid_i(v0), .req0_data_i(d0), .req0_ready_o(req0_ready),
        .req1_valid_i(v1), .req1_data_i(d1), .req1_ready_o(req1_ready),
        .out_valid_o(out_valid), .out_ready_i(ordy), .out_data_o(out_data),
        .out_src_o(out_src), .count_o(count),
        .buf_wr_en_o(buf_wr_en), .buf_wr_ptr_o(buf_wr_ptr), .buf_wr_data_o(buf_wr_data),
        .buf_rd_en_o(buf_rd_en), .buf_rd_ptr_o(buf_rd_ptr), .buf_rd_data_i(buf_rd_data)
    );

    // Attached buffer: synchronous write, combinational read.
    always @(posedge clk) if (buf_wr_en) mem[buf_wr_ptr] <= buf_wr_data;
    assign buf_rd_data = mem[buf_rd_ptr];

    function automatic logic [DW-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference rules for who wins, whether a push is taken, and whether a pop happens.
    function automatic bit m_win();
        if (v0 && v1) begin
`ifdef SPW_BUF_CTRL_RR_EN
            return !m_lg;
`else
            return 1'b0;
`endif
        end
        return v1 ? 1'b1 : 1'b0;
    endfunction

    function automatic bit m_push();
        return rst_n && (v0 || v1) && (q.size() < DEPTH);
    endfunction

    function automatic bit m_pop();
        return rst_n && (q.size() > 0) && ordy;
    endfunction

    task automatic model_reset();
        q.delete();
        m_lg = 1'b1;
        wp = 0;
        rp = 0;
    endtask

    // Clock edge that advances the reference model alongside the DUT.
    task automatic tick();
        bit p, o, w;
        p = m_push();
        o = m_pop();
        w = m_win();
        @(posedge clk);
        if (o) begin
            void'(q.pop_front());
            rp = (rp + 1) % DEPTH;
        end
        if (p) begin
            q.push_back({w, w ? d1 : d0});
            m_lg = w;
            wp = (wp + 1) % DEPTH;
        end
        #1;
    endtask

    task automatic idle();
        v0 = 1'b0;
        v1 = 1'b0;
        ordy = 1'b0;
    endtask

    task automatic reset_dut();
        idle();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        v0 = 1'b1;
        v1 = 1'b1;
        ordy = 1'b1;
        d0 = rnd();
        d1 = rnd();
        #2;
        n_total++; if (req0_ready !== 1'b0) $display("FAIL rst_ready0: got %b want 0", req0_ready); else n_pass++;
        n_total++; if (req1_ready !== 1'b0) $display("FAIL rst_ready1: got %b want 0", req1_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (buf_wr_en !== 1'b0 || buf_rd_en !== 1'b0) $display("FAIL rst_en: got wr=%b rd=%b want 0 0", buf_wr_en, buf_rd_en); else n_pass++;
        n_total++; if (count !== 4'd0 || out_src !== 1'b0) $display("FAIL rst_count_src: got %0d/%b want 0/0", count, out_src); else n_pass++;
        @(posedge clk);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] a;
        for (int i = 0; i < 3; i++) begin
            v0 = 1'b1;
            d0 = rnd();
            if (i == 0) a = d0;
            #1;
            n_total++; if (req0_ready !== 1'b1) $display("FAIL basic_ready0[%0d]: got %b want 1", i, req0_ready); else n_pass++;
            tick();
        end
        v0 = 1'b0;
        #1;
        n_total++; if (count !== 4'd3) $display("FAIL basic_count: got %0d want 3", count); else n_pass++;
        n_total++; if (out_valid !== 1'b1 || out_src !== 1'b0) $display("FAIL basic_head: got valid=%b src=%b want 1 0", out_valid, out_src); else n_pass++;
        n_total++; if (out_data !== a) $display("FAIL basic_data: got %h want %h", out_data, a); else n_pass++;
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            v0 = 1'b1;
            d0 = rnd();
            tick();
        end
        v0 = 1'b0;
        v1 = 1'b1;
        d1 = rnd();
        #1;
        n_total++; if (req1_ready !== 1'b0 || count !== 4'd8) $display("FAIL full_hold: got ready=%b count=%0d want 0 8", req1_ready, count); else n_pass++;
        ordy = 1'b1;
        #1;
        n_total++; if (req1_ready !== 1'b0) $display("FAIL full_pop_same_cycle: got %b want 0", req1_ready); else n_pass++;
        tick();
        ordy = 1'b0;
        #1;
        n_total++; if (req1_ready !== 1'b1 || count !== 4'd7) $display("FAIL full_after_pop: got ready=%b count=%0d want 1 7", req1_ready, count); else n_pass++;
        tick();
        v1 = 1'b0;
        #1;
        n_total++; if (count !== 4'd8) $display("FAIL full_refill: got %0d want 8", count); else n_pass++;
    endtask

    task automatic test_arbitration();
        bit e;
        reset_dut();
        ordy = 1'b1;
        v0 = 1'b1;
        v1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef SPW_BUF_CTRL_RR_EN
            e = (k % 2 == 1);
`else
            e = 1'b0;
`endif
            d0 = rnd();
            d1 = rnd();
            #1;
            n_total++; if (req0_ready !== !e || req1_ready !== e) $display("FAIL arb_grant[%0d]: got r0=%b r1=%b want winner %0d", k, req0_ready, req1_ready, e); else n_pass++;
            tick();
            n_total++; if (out_src !== e) $display("FAIL arb_out_src[%0d]: got %b want %b", k, out_src, e); else n_pass++;
        end
        v0 = 1'b0;
        v1 = 1'b0;
        tick();
        ordy = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] n;
        reset_dut();
        v0 = 1'b1;
        d0 = rnd();
        tick();
        v0 = 1'b0;
        v1 = 1'b1;
        n = rnd();
        d1 = n;
        ordy = 1'b1;
        tick();
        idle();
        #1;
        n_total++; if (count !== 4'd1 || out_src !== 1'b1) $display("FAIL simul_count_src: got %0d/%b want 1/1", count, out_src); else n_pass++;
        n_total++; if (out_data !== n) $display("FAIL simul_head: got %h want %h", out_data, n); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            v0 = 1'b1;
            d0 = rnd();
            ordy = 1'b1;
            #1;
            n_total++; if (out_data !== q[0][DW-1:0] || count !== 4'd1) $display("FAIL wrap_order[%0d]: got %h cnt %0d want %h cnt 1", i, out_data, count, q[0][DW-1:0]); else n_pass++;
            tick();
        end
        idle();
    endtask

    task automatic test_random();
        bit e0, e1, w;
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            v0 = ($urandom_range(0, 99) < 55);
            v1 = ($urandom_range(0, 99) < 55);
            ordy = ($urandom_range(0, 99) < 50);
            d0 = rnd();
            d1 = rnd();
            #1;
            w = m_win();
            e0 = m_push() && !w && v0;
            e1 = m_push() && w && v1;
            n_total++; if (req0_ready !== e0 || req1_ready !== e1) $display("FAIL rand_ready[%0d]: got %b%b want %b%b", i, req0_ready, req1_ready, e0, e1); else n_pass++;
            n_total++; if (buf_wr_en !== m_push() || buf_rd_en !== m_pop()) $display("FAIL rand_en[%0d]: got wr=%b rd=%b want %b %b", i, buf_wr_en, buf_rd_en, m_push(), m_pop()); else n_pass++;
            n_total++; if (m_push() && (buf_wr_ptr !== PW'(wp) || buf_wr_data !== (w ? d1 : d0))) $display("FAIL rand_wr[%0d]: got ptr %0d want %0d", i, buf_wr_ptr, wp); else n_pass++;
            n_total++; if (count !== 4'(q.size()) || out_valid !== (q.size() > 0)) $display("FAIL rand_count[%0d]: got %0d/%b want %0d", i, count, out_valid, q.size()); else n_pass++;
            if (q.size() > 0) begin
                n_total++; if (out_data !== q[0][DW-1:0] || out_src !== q[0][DW]) $display("FAIL rand_head[%0d]: got %h/%b want %h/%b", i, out_data, out_src, q[0][DW-1:0], q[0][DW]); else n_pass++;
            end
            tick();
        end
        idle();
    endtask

    task automatic test_midreset();
        logic [DW-1:0] x;
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            v0 = 1'(i % 2 == 0);
            v1 = 1'(i % 2 == 1);
            d0 = rnd();
            d1 = rnd();
            tick();
        end
        idle();
        #1;
        n_total++; if (count !== 4'd5) $display("FAIL midrst_pre_count: got %0d want 5", count); else n_pass++;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total++; if (count !== 4'd0 || out_valid !== 1'b0) $display("FAIL midrst_clear: got %0d/%b want 0/0", count, out_valid); else n_pass++;
        x = rnd();
        v0 = 1'b1;
        d0 = x;
        #1;
        n_total++; if (req0_ready !== 1'b0) $display("FAIL midrst_ready_in_reset: got %b want 0", req0_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++; if (req0_ready !== 1'b1) $display("FAIL midrst_first_push: got %b want 1", req0_ready); else n_pass++;
        tick();
        v0 = 1'b0;
        #1;
        n_total++; if (out_data !== x || count !== 4'd1) $display("FAIL midrst_data: got %h cnt %0d want %h cnt 1", out_data, count, x); else n_pass++;
    endtask

    initial begin
        idle();
        d0 = '0;
        d1 = '0;
        test_reset();
        test_basic();
        test_full();
        test_arbitration();
        test_simultaneous();
        test_random();
        test_midreset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
